// File: rtl/snes_pad_responder_pkg.sv
// Shared SNES joypad definitions: button bit positions, frame layout and
// the responder state encoding.
package snes_pkg;

   localparam int SNES_B      = 0;
   localparam int SNES_Y      = 1;
   localparam int SNES_SELECT = 2;
   localparam int SNES_START  = 3;
   localparam int SNES_UP     = 4;
   localparam int SNES_DOWN   = 5;
   localparam int SNES_LEFT   = 6;
   localparam int SNES_RIGHT  = 7;
   localparam int SNES_A      = 8;
   localparam int SNES_X      = 9;
   localparam int SNES_L      = 10;
   localparam int SNES_R      = 11;

   localparam int         SNES_FRAME_BITS = 16;
   localparam logic [3:0] SNES_ID_BITS    = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } snes_state_t;

   // Wire format is active low, ID nibble above the twelve buttons.
   function automatic logic [SNES_FRAME_BITS-1:0] snes_frame(input logic [11:0] buttons);
      return {SNES_ID_BITS, ~buttons};
   endfunction

endpackage

// File: rtl/snes_pad_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line, followed by a registered
// rising-edge detector whose level and pulse outputs are cycle-aligned.
module sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              last_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= {STAGES{RESET_VAL}};
         last_q <= RESET_VAL;
         rise   <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         last_q <= sync_q[STAGES-1];
         rise   <= sync_q[STAGES-1] & ~last_q;
      end
   end

   assign level = last_q;

endmodule

// File: rtl/snes_pad_responder.sv
// SNES controller-side responder: follows the host latch/clock lines and
// shifts a 16-bit active-low button frame out on controller_data.
module snes_pad_responder
   import snes_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 33333
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] button_state,
   input  logic        controller_latch,
   input  logic        controller_clock,
   output logic        controller_data,
   output logic        frame_done,
   output logic        timeout_err
);

   localparam int IW = $clog2(TIMEOUT + 1);

   logic lat_s, lat_rise;
   logic clk_s, clk_rise;
   logic shift_edge;

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_lat_sync (
      .clock (clock),
      .reset (reset),
      .din   (controller_latch),
      .level (lat_s),
      .rise  (lat_rise)
   );

   // Shift clock idles high, so its synchronizer resets high.
   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk_sync (
      .clock (clock),
      .reset (reset),
      .din   (controller_clock),
      .level (clk_s),
      .rise  (clk_rise)
   );

   assign shift_edge = clk_rise & clk_s;

   snes_state_t                state_q, state_n;
   logic [SNES_FRAME_BITS-1:0] shreg_q, shreg_n;
   logic [4:0]                 bit_cnt_q, bit_cnt_n;
   logic [IW-1:0]              idle_q, idle_n;
   logic                       done_n, tout_n;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         shreg_q     <= '1;
         bit_cnt_q   <= '0;
         idle_q      <= '0;
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_n;
         shreg_q     <= shreg_n;
         bit_cnt_q   <= bit_cnt_n;
         idle_q      <= idle_n;
         frame_done  <= done_n;
         timeout_err <= tout_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      shreg_n   = shreg_q;
      bit_cnt_n = bit_cnt_q;
      idle_n    = idle_q;
      done_n    = 1'b0;
      tout_n    = 1'b0;
      case (state_q)
         IDLE: begin
            if (lat_s) begin
               state_n = LOAD;
               shreg_n = snes_frame(button_state);
            end
         end
         LOAD: begin
            if (lat_s) begin
               shreg_n = snes_frame(button_state);
            end else begin
               state_n   = SHIFT;
               bit_cnt_n = '0;
               idle_n    = '0;
            end
         end
         SHIFT: begin
            // A latch edge outranks a coincident clock edge.
            if (lat_rise) begin
               state_n = LOAD;
               shreg_n = snes_frame(button_state);
            end else if (shift_edge) begin
               shreg_n   = {1'b0, shreg_q[SNES_FRAME_BITS-1:1]};
               bit_cnt_n = bit_cnt_q + 5'd1;
               idle_n    = '0;
               if (bit_cnt_q == 5'(SNES_FRAME_BITS - 1)) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
            end else if (idle_q == IW'(TIMEOUT - 1)) begin
               state_n = IDLE;
               tout_n  = 1'b1;
            end else begin
               idle_n = idle_q + 1'b1;
            end
         end
         DONE: begin
            if (lat_s) begin
               state_n = LOAD;
               shreg_n = snes_frame(button_state);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign controller_data = (state_q == IDLE) ? 1'b1 : shreg_q[0];

endmodule
